// File: rtl/bp_cce_deserializer.sv
// Merges pairs of 32-bit narrow memory commands into one 64-bit wide command,
// and splits each 64-bit wide response back into two 32-bit narrow responses.
module bp_cce_deserializer #(
  parameter int unsigned bp_params_p = 0,  // 0 = e_bp_default_cfg
  localparam int paddr_width_lp    = (bp_params_p == 0) ? 40 : 56,
  localparam int msg_type_width_lp = 4,
  localparam int size_width_lp     = 3,
  localparam int hdr_width_lp      = 64,
  localparam int word_width_lp     = 32,
  localparam int dword_width_lp    = 64,
  localparam int split_mem_msg_width_lp = hdr_width_lp + word_width_lp,
  localparam int cce_mem_msg_width_lp   = hdr_width_lp + dword_width_lp
) (
  input  logic                              clk_i,
  input  logic                              reset_i,

  input  logic [split_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                              io_cmd_v_i,
  output logic                              io_cmd_yumi_o,

  output logic [cce_mem_msg_width_lp-1:0]   io_cmd_o,
  output logic                              io_cmd_v_o,
  input  logic                              io_cmd_ready_i,

  input  logic [cce_mem_msg_width_lp-1:0]   io_resp_i,
  input  logic                              io_resp_v_i,
  output logic                              io_resp_yumi_o,

  output logic [split_mem_msg_width_lp-1:0] io_resp_o,
  output logic                              io_resp_v_o,
  input  logic                              io_resp_ready_i
);

  // Header layout: {payload, size, addr, msg_type}, msg_type in the LSBs.
  localparam int addr_lsb_lp = msg_type_width_lp;
  localparam int size_lsb_lp = addr_lsb_lp + paddr_width_lp;

  localparam logic [size_width_lp-1:0] e_bedrock_msg_size_4 = 3'b010;
  localparam logic [size_width_lp-1:0] e_bedrock_msg_size_8 = 3'b011;

  typedef enum logic {
    e_cmd_lo,
    e_cmd_hi
  } cmd_state_e;

  cmd_state_e               cmd_state_r;
  logic [hdr_width_lp-1:0]  cmd_hdr_r;
  logic [word_width_lp-1:0] cmd_data_lo_r;
  logic                     resp_cnt_r;

  logic [hdr_width_lp-1:0]   cmd_hdr_li;
  logic [word_width_lp-1:0]  cmd_data_li;
  logic [hdr_width_lp-1:0]   cmd_hdr_merged;
  logic [hdr_width_lp-1:0]   resp_hdr_li;
  logic [hdr_width_lp-1:0]   resp_hdr_split;
  logic [paddr_width_lp-1:0] resp_addr_li;
  logic [word_width_lp-1:0]  resp_data_split;

  assign cmd_hdr_li  = io_cmd_i[0+:hdr_width_lp];
  assign cmd_data_li = io_cmd_i[hdr_width_lp+:word_width_lp];

  // Command path: the second half is passed through combinationally and
  // joined with the registered first half.
  always_comb begin
    cmd_hdr_merged = cmd_hdr_r;
    cmd_hdr_merged[size_lsb_lp+:size_width_lp] = e_bedrock_msg_size_8;
    io_cmd_o      = {cmd_data_li, cmd_data_lo_r, cmd_hdr_merged};
    io_cmd_v_o    = 1'b0;
    io_cmd_yumi_o = 1'b0;
    if (!reset_i) begin
      case (cmd_state_r)
        e_cmd_lo: io_cmd_yumi_o = io_cmd_v_i;
        e_cmd_hi: begin
          io_cmd_v_o    = io_cmd_v_i;
          io_cmd_yumi_o = io_cmd_v_i & io_cmd_ready_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmd_state_r   <= e_cmd_lo;
      cmd_hdr_r     <= '0;
      cmd_data_lo_r <= '0;
    end else begin
      case (cmd_state_r)
        e_cmd_lo: if (io_cmd_v_i) begin
          cmd_hdr_r     <= cmd_hdr_li;
          cmd_data_lo_r <= cmd_data_li;
          cmd_state_r   <= e_cmd_hi;
        end
        e_cmd_hi: if (io_cmd_yumi_o) cmd_state_r <= e_cmd_lo;
        default: cmd_state_r <= e_cmd_lo;
      endcase
    end
  end

  // Response path: the wide response stays at the input until its high half
  // has been handed to the initiator.
  assign resp_hdr_li  = io_resp_i[0+:hdr_width_lp];
  assign resp_addr_li = resp_hdr_li[addr_lsb_lp+:paddr_width_lp];

  always_comb begin
    resp_hdr_split = resp_hdr_li;
    resp_hdr_split[size_lsb_lp+:size_width_lp] = e_bedrock_msg_size_4;
    resp_hdr_split[addr_lsb_lp+:paddr_width_lp] =
      resp_addr_li + (paddr_width_lp'(resp_cnt_r) << 2);
    resp_data_split = resp_cnt_r
      ? io_resp_i[hdr_width_lp+word_width_lp+:word_width_lp]
      : io_resp_i[hdr_width_lp+:word_width_lp];
  end

  assign io_resp_o      = {resp_data_split, resp_hdr_split};
  assign io_resp_v_o    = io_resp_v_i & ~reset_i;
  assign io_resp_yumi_o = io_resp_v_i & io_resp_ready_i & resp_cnt_r & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      resp_cnt_r <= 1'b0;
    else if (io_resp_v_o & io_resp_ready_i)
      resp_cnt_r <= ~resp_cnt_r;
  end

  // Protocol checks on the traffic this block expects to see.
  a_cmd_size: assert property (@(posedge clk_i) disable iff (reset_i)
    io_cmd_yumi_o |-> cmd_hdr_li[size_lsb_lp+:size_width_lp] == e_bedrock_msg_size_4);
  a_cmd_lo_align: assert property (@(posedge clk_i) disable iff (reset_i)
    (io_cmd_yumi_o && cmd_state_r == e_cmd_lo) |-> !cmd_hdr_li[addr_lsb_lp+2]);
  a_cmd_hi_match: assert property (@(posedge clk_i) disable iff (reset_i)
    (io_cmd_yumi_o && cmd_state_r == e_cmd_hi) |->
      (cmd_hdr_li[addr_lsb_lp+:paddr_width_lp] ==
         cmd_hdr_r[addr_lsb_lp+:paddr_width_lp] + paddr_width_lp'(4))
      && (cmd_hdr_li[0+:msg_type_width_lp] == cmd_hdr_r[0+:msg_type_width_lp]));
  a_resp_size: assert property (@(posedge clk_i) disable iff (reset_i)
    io_resp_v_i |-> resp_hdr_li[size_lsb_lp+:size_width_lp] == e_bedrock_msg_size_8);

endmodule

// File: tb/tb_bp_cce_deserializer.sv
// Scoreboard bench for bp_cce_deserializer: drivers push expected merges and
// splits into queues, monitors pop and compare on each output handshake.
module tb_bp_cce_deserializer;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [95:0]  io_cmd_i;
  logic         io_cmd_v_i;
  logic         io_cmd_yumi_o;
  logic [127:0] io_cmd_o;
  logic         io_cmd_v_o;
  logic         io_cmd_ready_i;
  logic [127:0] io_resp_i;
  logic         io_resp_v_i;
  logic         io_resp_yumi_o;
  logic [95:0]  io_resp_o;
  logic         io_resp_v_o;
  logic         io_resp_ready_i;

  bp_cce_deserializer dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_yumi_o(io_cmd_yumi_o),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_ready_i(io_resp_ready_i)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  localparam logic [2:0] size4 = 3'b010;
  localparam logic [2:0] size8 = 3'b011;
  localparam int bound = 1000;

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;  // 0 manual, 1 random, 2 toggle response ready

  logic [127:0] exp_cmd_q[$];
  logic [96:0]  exp_resp_q[$];  // {expected yumi, narrow response}

  function automatic logic [63:0] mk_hdr(logic [3:0] t, logic [39:0] a,
                                         logic [2:0] s, logic [16:0] p);
    return {p, s, a, t};
  endfunction

  function automatic logic [39:0] rand_addr();
    return {8'h00, 32'h8000_0000 | ($urandom & 32'h0fff_fff8)};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout after %0d cycles, expected handshake", name, bound);
  endtask

  // Driver tasks
  task automatic send_half(logic [95:0] msg);
    int n = 0;
    io_cmd_i   = msg;
    io_cmd_v_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (io_cmd_yumi_o) break;
      if (++n >= bound) begin timeout("cmd_half_wait"); break; end
    end
    @(posedge clk_i); #1;
    io_cmd_v_i = 1'b0;
  endtask

  task automatic send_cmd_pair(logic [3:0] t, logic [39:0] a, logic [31:0] lo,
                               logic [31:0] hi, logic [16:0] p);
    exp_cmd_q.push_back({hi, lo, mk_hdr(t, a, size8, p)});
    send_half({lo, mk_hdr(t, a, size4, p)});
    send_half({hi, mk_hdr(t, a + 40'd4, size4, p)});
  endtask

  task automatic send_resp(logic [3:0] t, logic [39:0] a, logic [63:0] d,
                           logic [16:0] p);
    int n = 0;
    exp_resp_q.push_back({1'b0, d[31:0],  mk_hdr(t, a, size4, p)});
    exp_resp_q.push_back({1'b1, d[63:32], mk_hdr(t, a + 40'd4, size4, p)});
    io_resp_i   = {d, mk_hdr(t, a, size8, p)};
    io_resp_v_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (io_resp_yumi_o) break;
      if (++n >= bound) begin timeout("resp_wait"); break; end
    end
    @(posedge clk_i); #1;
    io_resp_v_i = 1'b0;
  endtask

  // Ready generator
  initial forever begin
    @(posedge clk_i); #1;
    if (rdy_mode == 1) begin
      io_cmd_ready_i  = 1'($urandom_range(0, 1));
      io_resp_ready_i = 1'($urandom_range(0, 1));
    end else if (rdy_mode == 2) begin
      io_resp_ready_i = ~io_resp_ready_i;
    end
  end

  // Scoreboard monitors
  initial forever begin
    @(negedge clk_i);
    if (!reset_i && io_cmd_v_o && io_cmd_ready_i) begin
      if (exp_cmd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL cmd_unexpected: got %h expected no command", io_cmd_o);
      end else begin
        check("cmd_merge", io_cmd_o, exp_cmd_q.pop_front());
        check("cmd_yumi_on_accept", 128'(io_cmd_yumi_o), 128'd1);
      end
    end
    if (!reset_i && io_resp_v_o && io_resp_ready_i) begin
      if (exp_resp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL resp_unexpected: got %h expected no response", io_resp_o);
      end else begin
        check("resp_split", 128'({io_resp_yumi_o, io_resp_o}), 128'(exp_resp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [63:0] d;
    logic [39:0] a;
    int n;

    reset_i = 1'b1;
    io_cmd_i = '0;
    io_cmd_v_i = 1'b1;
    io_cmd_ready_i = 1'b1;
    io_resp_i = {64'h0, mk_hdr(4'h0, 40'h0, size8, 17'h0)};
    io_resp_v_i = 1'b1;
    io_resp_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_cmd_v_o", 128'(io_cmd_v_o), 128'd0);
    check("rst_cmd_yumi_o", 128'(io_cmd_yumi_o), 128'd0);
    check("rst_resp_v_o", 128'(io_resp_v_o), 128'd0);
    check("rst_resp_yumi_o", 128'(io_resp_yumi_o), 128'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    io_cmd_v_i = 1'b0;
    io_resp_v_i = 1'b0;

    // Directed write merge
    send_cmd_pair(4'h1, 40'h00_8000_0000, 32'h1111_2222, 32'h3333_4444, 17'h0);
    @(negedge clk_i);
    check("cmd_v_o_idle", 128'(io_cmd_v_o), 128'd0);
    @(posedge clk_i); #1;

    // Command backpressure for 5 cycles
    io_cmd_ready_i = 1'b0;
    exp_cmd_q.push_back({32'hDEAD_BEEF, 32'h0BAD_F00D, mk_hdr(4'h1, 40'h00_8000_0100, size8, 17'h5)});
    send_half({32'h0BAD_F00D, mk_hdr(4'h1, 40'h00_8000_0100, size4, 17'h5)});
    io_cmd_i = {32'hDEAD_BEEF, mk_hdr(4'h1, 40'h00_8000_0104, size4, 17'h5)};
    io_cmd_v_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("bp_cmd_v_o", 128'(io_cmd_v_o), 128'd1);
      check("bp_cmd_yumi_o", 128'(io_cmd_yumi_o), 128'd0);
      check("bp_cmd_stable", io_cmd_o,
            {32'hDEAD_BEEF, 32'h0BAD_F00D, mk_hdr(4'h1, 40'h00_8000_0100, size8, 17'h5)});
    end
    @(posedge clk_i); #1;
    io_cmd_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_accept_on_ready", 128'(io_cmd_yumi_o), 128'd1);
    @(posedge clk_i); #1;
    io_cmd_v_i = 1'b0;

    // Directed read response split
    send_resp(4'h0, 40'h00_8000_0040, 64'hAAAA_BBBB_CCCC_DDDD, 17'h0);

    // Response ready toggling
    rdy_mode = 2;
    for (int i = 0; i < 4; i++)
      send_resp(4'($urandom_range(0, 15)), rand_addr(), {$urandom, $urandom},
                17'($urandom_range(0, 17'h1ffff)));
    rdy_mode = 0;
    @(posedge clk_i); #1;
    io_resp_ready_i = 1'b1;
    check("resp_cnt_idle", 128'(dut.resp_cnt_r), 128'd0);

    // Reset with a command first half held
    send_half({32'h7777_7777, mk_hdr(4'h1, 40'h00_8000_0200, size4, 17'h0)});
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i); #1;
    reset_i = 1'b0;
    send_cmd_pair(4'h1, 40'h00_8000_0300, 32'h5555_6666, 32'h8888_9999, 17'h3);

    // Reset between the two halves of a response
    d = 64'h0123_4567_89AB_CDEF;
    a = 40'h00_8000_0400;
    exp_resp_q.push_back({1'b0, d[31:0], mk_hdr(4'h0, a, size4, 17'h0)});
    io_resp_i = {d, mk_hdr(4'h0, a, size8, 17'h0)};
    io_resp_v_i = 1'b1;
    @(negedge clk_i);
    check("rst_resp_low_first", 128'(io_resp_yumi_o), 128'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    io_resp_v_i = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    reset_i = 1'b0;
    send_resp(4'h0, 40'h00_8000_0500, 64'hFEDC_BA98_7654_3210, 17'h9);

    // Concurrent random streams
    rdy_mode = 1;
    fork
      for (int i = 0; i < 100; i++) begin
        send_cmd_pair(4'($urandom_range(0, 15)), rand_addr(), $urandom, $urandom,
                      17'($urandom_range(0, 17'h1ffff)));
        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      end
      for (int i = 0; i < 100; i++) begin
        send_resp(4'($urandom_range(0, 15)), rand_addr(), {$urandom, $urandom},
                  17'($urandom_range(0, 17'h1ffff)));
        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      end
    join
    rdy_mode = 0;
    io_cmd_ready_i = 1'b1;
    io_resp_ready_i = 1'b1;

    n = 0;
    while ((exp_cmd_q.size() != 0 || exp_resp_q.size() != 0) && n < 20) begin
      @(posedge clk_i);
      n++;
    end
    check("cmd_queue_drained", 128'(exp_cmd_q.size()), 128'd0);
    check("resp_queue_drained", 128'(exp_resp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
